// File: rtl/pipelined_alu.sv
// Handshaked ALU with registered result/flags; ops complete in one cycle, except mul,
// which is iterative (WIDTH cycles) and exists only when PIPELINED_ALU_MUL_EN is defined.
module pipelined_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             err;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic rsp_t compute(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [3:0] sel);
    rsp_t           r;
    logic [WIDTH:0] sum;
    logic [SHW-1:0] sh;
    r   = '0;
    sum = '0;
    sh  = b[SHW-1:0];
    case (sel)
      4'b0000: begin
        sum     = {1'b0, a} + {1'b0, b};
        r.res   = sum[WIDTH-1:0];
        r.carry = sum[WIDTH];
        r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        // carry out of a + ~b + 1 is the no-borrow flag
        sum     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        r.res   = sum[WIDTH-1:0];
        r.carry = sum[WIDTH];
        r.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: r.res = a & b;
      4'b0011: r.res = a | b;
      4'b0100: r.res = a ^ b;
      4'b0101: r.res = ~(a | b);
      4'b0110: r.res = ~(a & b);
      4'b0111: r.res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1000: r.res = {{(WIDTH-1){1'b0}}, a < b};
      4'b1001: r.res = a << sh;
      4'b1010: r.res = a >> sh;
      4'b1011: r.res = $signed(a) >>> sh;
      default: r.err = 1'b1;
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  state_t state, state_n;
  rsp_t   rsp_q, rsp_d;
  logic   accept, is_mul;

`ifdef PIPELINED_ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, acc, acc_n;
  logic [CW-1:0]    cnt;

  assign is_mul = (ALU_Sel == 4'b1100);
  assign acc_n  = acc + (mplier[0] ? mcand : '0);
`else
  assign is_mul = 1'b0;
`endif

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign rsp_d     = compute(A, B, ALU_Sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = is_mul ? BUSY : DONE;
`ifdef PIPELINED_ALU_MUL_EN
      BUSY: if (cnt == CW'(1)) state_n = DONE;
`endif
      DONE: begin
        if (accept)         state_n = is_mul ? BUSY : DONE;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // result register only moves on a single-cycle accept or the final mul step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else if (accept && !is_mul) begin
      rsp_q <= rsp_d;
`ifdef PIPELINED_ALU_MUL_EN
    end else if ((state == BUSY) && (cnt == CW'(1))) begin
      rsp_q <= {acc_n, acc_n == '0, 3'b000};
`endif
    end
  end

`ifdef PIPELINED_ALU_MUL_EN
  // shift-and-add: one multiplier bit per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (state == BUSY) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
`endif

  assign ALU_Out  = rsp_q.res;
  assign Zero     = rsp_q.zero;
  assign Carry    = rsp_q.carry;
  assign Overflow = rsp_q.ovf;
  assign Err      = rsp_q.err;
endmodule
